vscale_fetch_queue: RTL and testbench
=====================================

Name: vscale_fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-register IF stage. It prefetches sequential instruction words from the instruction memory port into a DEPTH-entry FIFO of {pc, inst, badmem} entries. It presents them to the decode/execute stage with a valid/ready handshake. Redirects (branch, jump, trap) flush the queue and discard any in-flight response.

Parameters:
XPR_LEN, 32, data/address width in bits.
DEPTH, 4, queue entries; power of two, 2..16.
RESET_PC, 32'h200, first fetch address after reset.
BYPASS_EN, 1, 1 = an arriving response may be presented the same cycle when the queue is empty.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  XPR_LEN  new fetch address
imem_req  out  1  request valid this cycle
imem_addr  out  XPR_LEN  request address
imem_wait  in  1  memory stall
imem_rdata  in  32  response instruction word
imem_badmem_e  in  1  response access fault
inst_valid  out  1  head entry valid
inst_ready  in  1  consumer accepts head (~stall_DX)
inst  out  32  head instruction
inst_pc  out  XPR_LEN  head PC
inst_badmem  out  1  head fault flag
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Memory protocol:
  - A request is accepted in cycle N iff imem_req & ~imem_wait.
  - Its response is valid in the first cycle M>N with imem_wait=0.
  - A new request may be accepted in cycle M. At most one request is outstanding.
  - While imem_wait=1, imem_addr holds its value.
- Reset (reset_n=0 at a clock edge):
  - count=0, inst_valid=0, outstanding=0, drop=0, halted=0.
  - fetch_pc=RESET_PC.
  - imem_req=0 during reset; 1 in the first cycle after reset.
- Issue: imem_req = ~halted & (count + outstanding < DEPTH). No credit is taken for a pop in the same cycle.
- Address and pointer:
  - imem_addr = redirect_valid ? redirect_pc : fetch_pc.
  - On accept, fetch_pc <= imem_addr + 4; the addition wraps modulo 2^XPR_LEN.
- Response, not dropped: push {pc_of_request, imem_rdata, imem_badmem_e}.
  - The PC comes from a registered copy of the accepted address.
  - If imem_badmem_e=1, set halted; it stays set until a redirect.
- Bypass (BYPASS_EN=1): when count=0 and a valid response arrives:
  - inst_valid=1 combinationally with response fields.
  - If inst_ready=1, the entry is not written.
- Pop: on inst_valid & inst_ready. Simultaneous push and pop leaves count unchanged.
  - Push when full cannot occur, because issue is credit-limited.
  - An assertion flags a violation.
- Redirect (redirect_valid=1 in cycle R):
  - All entries are invalidated at the R edge. inst_valid is forced 0 in cycle R; any pop in R is ignored.
  - halted is cleared.
  - If a request is outstanding and its response does not complete in R, set drop. The next completing response is discarded and drop clears.
  - A response completing in R itself is discarded.
  - If imem_wait=0 in R, redirect_pc is issued in R, so the first redirected instruction is valid no earlier than R+1 (bypass) or R+2.
  - If imem_wait=1, fetch_pc <= redirect_pc and issue follows once wait drops.
- Redirect and reset together: reset wins.
- Outputs when inst_valid=0: inst=32'h00000013 (NOP); inst_pc and inst_badmem are don't-care.
- count reflects registered occupancy; it excludes bypass.

Decomposition:
- Shared constants in the existing control-constants header: RV_NOP, INST_WIDTH, XPR_LEN.
- One sub-module, vscale_fetch_fifo: a generic DEPTH-entry synchronous FIFO with flush, providing push/pop/full/empty/count.
- vscale_fetch_queue holds the request/response tracking, drop/halted flags and bypass mux.

Test Plan:
1. Reset release, imem_wait=0, inst_ready=1, DEPTH=4 -> imem_addr 0x200, 0x204, 0x208… on consecutive cycles; inst_pc follows one cycle behind with BYPASS_EN=1 (two cycles with BYPASS_EN=0).
2. inst_ready=0, no wait -> exactly 4 requests accepted (0x200–0x20C); imem_req=0 afterwards; count=4. Then one pop -> a single request to 0x210.
3. Outstanding request to 0x208, imem_wait=1 for 3 cycles, redirect_valid with redirect_pc=0x400 in the first wait cycle -> the 0x208 response is discarded; the next accepted address is 0x400 and the next inst_pc is 0x400.
4. Response for 0x20C with imem_badmem_e=1 -> entry has inst_badmem=1; no further requests. Then redirect to 0x100 -> fetch resumes at 0x100.
5. Redirect in the same cycle as a pop and a push with count=2 -> count=0 next cycle; no stale PC ever appears on inst_pc.
6. reset_n=0 mid-stream with count=3 and a request outstanding -> next cycle count=0 and inst_valid=0; after release, fetch restarts at 0x200 and the stale response is never pushed.

Source files
------------

// File: rtl/vscale_fetch_queue_pkg.sv
// vscale_fetch_queue_pkg: shared fetch constants (instruction width, XPR length, NOP encoding)
package vscale_fetch_queue_pkg;
  localparam int XPR_LEN = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] RV_NOP = 32'h00000013;
endpackage

// File: rtl/vscale_fetch_fifo.sv
// vscale_fetch_fifo: DEPTH-entry sync FIFO with flush; ports clk, reset_n, flush, push/wdata, pop/rdata, full, empty, count
module vscale_fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign rdata = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk)
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/vscale_fetch_queue.sv
// vscale_fetch_queue: prefetching IF stage; ports clk, reset_n, redirect_valid/pc, imem_req/addr/wait/rdata/badmem_e, inst_valid/ready/inst/pc/badmem, count
module vscale_fetch_queue #(
  parameter int XPR_LEN = vscale_fetch_queue_pkg::XPR_LEN,
  parameter int DEPTH = 4,
  parameter logic [XPR_LEN-1:0] RESET_PC = 'h200,
  parameter bit BYPASS_EN = 1'b1,
  localparam int CW = $clog2(DEPTH) + 1
)(
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      redirect_valid,
  input  logic [XPR_LEN-1:0]                        redirect_pc,
  output logic                                      imem_req,
  output logic [XPR_LEN-1:0]                        imem_addr,
  input  logic                                      imem_wait,
  input  logic [vscale_fetch_queue_pkg::INST_WIDTH-1:0] imem_rdata,
  input  logic                                      imem_badmem_e,
  output logic                                      inst_valid,
  input  logic                                      inst_ready,
  output logic [vscale_fetch_queue_pkg::INST_WIDTH-1:0] inst,
  output logic [XPR_LEN-1:0]                        inst_pc,
  output logic                                      inst_badmem,
  output logic [CW-1:0]                             count
);
  import vscale_fetch_queue_pkg::*;
  localparam int EW = XPR_LEN + INST_WIDTH + 1;
  logic [XPR_LEN-1:0] fetch_pc, req_pc;
  logic outstanding, drop, halted;
  logic accept, resp, resp_keep, bypass, push, pop, fifo_empty, fifo_full;
  logic [EW-1:0] resp_entry, head;
  logic [INST_WIDTH-1:0] inst_raw;
  logic [CW:0] credit;
  assign credit = {1'b0, count} + (CW+1)'(outstanding);
  assign imem_addr = redirect_valid ? redirect_pc : fetch_pc;
  assign imem_req = reset_n & (redirect_valid | (~halted & (credit < (CW+1)'(DEPTH))));
  assign accept = imem_req & ~imem_wait;
  assign resp = outstanding & ~imem_wait;
  assign resp_keep = resp & ~drop & ~redirect_valid;
  assign resp_entry = {req_pc, imem_rdata, imem_badmem_e};
  assign bypass = BYPASS_EN & fifo_empty & resp_keep;
  assign inst_valid = ~redirect_valid & (~fifo_empty | bypass);
  assign {inst_pc, inst_raw, inst_badmem} = fifo_empty ? resp_entry : head;
  assign inst = inst_valid ? inst_raw : RV_NOP;
  assign pop = inst_valid & inst_ready & ~fifo_empty;
  assign push = resp_keep & ~(bypass & inst_ready);
  always_ff @(posedge clk)
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      outstanding <= 1'b0;
      drop <= 1'b0;
      halted <= 1'b0;
    end else begin
      fetch_pc <= accept ? imem_addr + XPR_LEN'(4) : redirect_valid ? redirect_pc : fetch_pc;
      req_pc <= accept ? imem_addr : req_pc;
      outstanding <= accept | (outstanding & imem_wait);
      drop <= redirect_valid ? outstanding & imem_wait : drop & ~resp;
      halted <= ~redirect_valid & (halted | (resp_keep & imem_badmem_e));
    end
  vscale_fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .flush(redirect_valid),
    .push(push),
    .wdata(resp_entry),
    .pop(pop),
    .rdata(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(count)
  );
  assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full));
endmodule

// File: tb/tb_vscale_fetch_queue.sv
// tb_vscale_fetch_queue: directed checks of prefetch, credit limit, redirect, fault halt and reset
module tb_vscale_fetch_queue;
  logic clk = 0, reset_n = 0, redirect_valid = 0, imem_wait = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0;
  logic imem_req, imem_badmem_e, inst_valid, inst_badmem;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
  logic [2:0] count;
  logic [31:0] pend_addr = 0, bad_addr = 32'hFFFF_FFFF;
  int checks = 0, failures = 0;

  vscale_fetch_queue dut (
    .clk(clk), .reset_n(reset_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait), .imem_rdata(imem_rdata),
    .imem_badmem_e(imem_badmem_e), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_badmem(inst_badmem), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_req && !imem_wait) pend_addr <= imem_addr;
  assign imem_rdata = 32'hC0DE_0000 | {16'h0, pend_addr[15:0]};
  assign imem_badmem_e = (pend_addr == bad_addr);

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset(input logic rdy);
    reset_n = 0;
    redirect_valid = 0;
    imem_wait = 0;
    inst_ready = rdy;
    bad_addr = 32'hFFFF_FFFF;
    tick;
    tick;
    reset_n = 1;
  endtask

  task test_reset;
    reset_n = 0;
    tick;
    tick;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", count); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (inst !== 32'h13) begin failures++; $display("FAIL reset_nop got=%h exp=00000013", inst); end
  endtask

  task test_stream;
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_req[%0d] got=%b exp=1", i, imem_req); end
      checks++; if (imem_addr !== 32'h200 + 32'(4*i)) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, imem_addr, 32'h200 + 32'(4*i)); end
      checks++; if (inst_valid !== (i > 0)) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, inst_valid, i > 0); end
      if (i > 0) begin
        checks++; if (inst_pc !== 32'h1FC + 32'(4*i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, inst_pc, 32'h1FC + 32'(4*i)); end
        checks++; if (inst !== 32'hC0DE_01FC + 32'(4*i)) begin failures++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, inst, 32'hC0DE_01FC + 32'(4*i)); end
      end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_count[%0d] got=%h exp=0", i, count); end
      tick;
    end
  endtask

  task test_credit;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (imem_req !== (i < 4)) begin failures++; $display("FAIL credit_req[%0d] got=%b exp=%b", i, imem_req, i < 4); end
      if (i < 4) begin
        checks++; if (imem_addr !== 32'h200 + 32'(4*i)) begin failures++; $display("FAIL credit_addr[%0d] got=%h exp=%h", i, imem_addr, 32'h200 + 32'(4*i)); end
      end
      checks++; if (count !== 3'(i < 2 ? 0 : i - 1)) begin failures++; $display("FAIL credit_count[%0d] got=%h exp=%h", i, count, 3'(i < 2 ? 0 : i - 1)); end
      tick;
    end
    inst_ready = 1;
    #1;
    checks++; if (inst_pc !== 32'h200) begin failures++; $display("FAIL credit_head got=%h exp=200", inst_pc); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL credit_popreq got=%b exp=0", imem_req); end
    tick;
    inst_ready = 0;
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL credit_afterpop got=%h exp=3", count); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h210) begin failures++; $display("FAIL credit_refill got=%b/%h exp=1/210", imem_req, imem_addr); end
    checks++; if (inst_pc !== 32'h204) begin failures++; $display("FAIL credit_head2 got=%h exp=204", inst_pc); end
    tick;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL credit_single got=%b exp=0", imem_req); end
    tick;
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL credit_full got=%h exp=4", count); end
  endtask

  task test_redirect_wait;
    do_reset(1'b1);
    tick;
    tick;
    tick;
    imem_wait = 1;
    redirect_valid = 1;
    redirect_pc = 32'h400;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h13) begin failures++; $display("FAIL rdw_cycleR got=%b/%h exp=0/00000013", inst_valid, inst); end
    tick;
    redirect_valid = 0;
    #1;
    checks++; if (imem_addr !== 32'h400) begin failures++; $display("FAIL rdw_hold got=%h exp=400", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdw_valid1 got=%b exp=0", inst_valid); end
    tick;
    tick;
    imem_wait = 0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rdw_dropped got=%b pc=%h exp=0", inst_valid, inst_pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL rdw_issue got=%b/%h exp=1/400", imem_req, imem_addr); end
    tick;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h400) begin failures++; $display("FAIL rdw_first got=%b/%h exp=1/400", inst_valid, inst_pc); end
    checks++; if (inst !== 32'hC0DE_0400) begin failures++; $display("FAIL rdw_inst got=%h exp=c0de0400", inst); end
    checks++; if (imem_addr !== 32'h404) begin failures++; $display("FAIL rdw_next got=%h exp=404", imem_addr); end
  endtask

  task test_badmem;
    do_reset(1'b1);
    bad_addr = 32'h20C;
    tick;
    tick;
    tick;
    tick;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20C || inst_badmem !== 1'b1) begin failures++; $display("FAIL bad_entry got=%b/%h/%b exp=1/20c/1", inst_valid, inst_pc, inst_badmem); end
    tick;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bad_halt1 got=%b exp=0", imem_req); end
    checks++; if (inst_pc !== 32'h210 || inst_badmem !== 1'b0) begin failures++; $display("FAIL bad_tail got=%h/%b exp=210/0", inst_pc, inst_badmem); end
    tick;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL bad_halt2 got=%b/%b exp=0/0", imem_req, inst_valid); end
    tick;
    redirect_valid = 1;
    redirect_pc = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL bad_resume got=%b/%h exp=1/100", imem_req, imem_addr); end
    tick;
    redirect_valid = 0;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_badmem !== 1'b0) begin failures++; $display("FAIL bad_after got=%b/%h/%b exp=1/100/0", inst_valid, inst_pc, inst_badmem); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin failures++; $display("FAIL bad_next got=%b/%h exp=1/104", imem_req, imem_addr); end
  endtask

  task test_redirect_pop_push;
    do_reset(1'b0);
    tick;
    tick;
    tick;
    #1;
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL rpp_pre got=%h exp=2", count); end
    inst_ready = 1;
    redirect_valid = 1;
    redirect_pc = 32'h300;
    #1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rpp_valid got=%b exp=0", inst_valid); end
    tick;
    redirect_valid = 0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rpp_count got=%h exp=0", count); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin failures++; $display("FAIL rpp_first got=%b/%h exp=1/300", inst_valid, inst_pc); end
    tick;
    #1;
    checks++; if (count !== 3'd0 || inst_pc !== 32'h304) begin failures++; $display("FAIL rpp_second got=%h/%h exp=0/304", count, inst_pc); end
  endtask

  task test_reset_mid;
    do_reset(1'b0);
    tick;
    tick;
    tick;
    tick;
    imem_wait = 1;
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL rmid_pre got=%h exp=3", count); end
    reset_n = 0;
    tick;
    reset_n = 1;
    imem_wait = 0;
    #1;
    checks++; if (count !== 3'd0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rmid_clear got=%h/%b exp=0/0", count, inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rmid_restart got=%b/%h exp=1/200", imem_req, imem_addr); end
    tick;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin failures++; $display("FAIL rmid_first got=%b/%h exp=1/200", inst_valid, inst_pc); end
    tick;
    #1;
    checks++; if (count !== 3'd1 || inst_pc !== 32'h200) begin failures++; $display("FAIL rmid_nostale got=%h/%h exp=1/200", count, inst_pc); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_credit;
    test_redirect_wait;
    test_badmem;
    test_redirect_pop_push;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
